// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex 7-segment display driver.
// Scans NUM_DIGITS digits, each selected for DWELL_CYCLES clocks. Supports
// per-digit decimal point, blanking and blink, 4-level brightness gating on
// the anode, selectable output polarity and a one-cycle frame tick.
// Outputs are registered: the value shown during a cycle reflects the
// prescaler/index state of the previous cycle.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLINK_DIV    = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [1:0]              bright,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(DWELL_CYCLES);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  // Deasserted (dark) levels for each output group.
  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic                  DP_OFF  = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PW-1:0] presc;
  logic [IW-1:0] index;
  logic [FW-1:0] fcnt;
  logic          phase_off;

  logic [3:0] hold_nib;
  logic       hold_dp;
  logic       hold_blank;
  logic       hold_blink;

  logic                  load;
  logic                  presc_wrap;
  logic                  frame_end;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_blink;
  logic                  lit;
  logic [6:0]            seg_lo;
  logic [PW+2:0]         on_prod;
  logic [PW+2:0]         on_time;
  logic                  an_gate;
  logic [NUM_DIGITS-1:0] an_hot;

  // Hex to segment pattern {g,f,e,d,c,b,a}, active-low form.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign load       = (presc == '0);
  assign presc_wrap = (presc == PRESC_LAST);
  assign frame_end  = presc_wrap && (index == INDEX_LAST);

  // During the load cycle the live inputs are used directly so the first
  // registered output of a dwell already shows the newly selected digit.
  assign cur_nib   = load ? digits[{index, 2'b00} +: 4] : hold_nib;
  assign cur_dp    = load ? dp[index]    : hold_dp;
  assign cur_blank = load ? blank[index] : hold_blank;
  assign cur_blink = load ? blink[index] : hold_blink;

  assign lit    = !cur_blank && !(cur_blink && phase_off);
  assign seg_lo = hex_to_seg(cur_nib);

  // ON_TIME = ((bright+1)*DWELL_CYCLES)/4; the product needs two extra bits
  // beyond the prescaler width, one more keeps the add carry safe.
  assign on_prod = (PW+3)'({1'b0, bright} + 3'd1) * (PW+3)'(DWELL_CYCLES);
  assign on_time = on_prod >> 2;
  assign an_gate = ({3'b000, presc} < on_time);
  assign an_hot  = NUM_DIGITS'(1) << index;

  // Prescaler, digit index, frame counter and blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      index     <= '0;
      fcnt      <= '0;
      phase_off <= 1'b0;
    end else if (presc_wrap) begin
      presc <= '0;
      if (index == INDEX_LAST) begin
        index <= '0;
        if (fcnt == FRAME_LAST) begin
          fcnt      <= '0;
          phase_off <= ~phase_off;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        index <= index + 1'b1;
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Capture the selected digit's attributes at the start of its dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_nib   <= 4'h0;
      hold_dp    <= 1'b0;
      hold_blank <= 1'b0;
      hold_blink <= 1'b0;
    end else if (load) begin
      hold_nib   <= cur_nib;
      hold_dp    <= cur_dp;
      hold_blank <= cur_blank;
      hold_blink <= cur_blink;
    end
  end

  // Registered pin drive; dark digits deassert everything, brightness
  // gating acts on the anode only.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF;
      dp_out     <= DP_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= lit ? (ACTIVE_LOW ? seg_lo : ~seg_lo) : SEG_OFF;
      dp_out     <= (lit && cur_dp) ? ~DP_OFF : DP_OFF;
      an         <= (lit && an_gate) ? (ACTIVE_LOW ? ~an_hot : an_hot) : AN_OFF;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: a 4-digit active-low instance and an
// 8-digit active-high instance, both checked cycle by cycle against a
// time-based reference model built from recorded input history.
module tb_seg7_scan_driver;

  localparam int D  = 8;
  localparam int BD = 2;
  localparam int HN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [15:0] digits;
  logic [3:0]  dp, blank, blink;
  logic [1:0]  bright;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_tick;

  logic [31:0] digits8;
  logic [7:0]  dp8, blank8, blink8;
  logic [1:0]  bright8;
  logic [6:0]  seg8;
  logic        dp_out8;
  logic [7:0]  an8;
  logic        frame_tick8;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .DWELL_CYCLES(D), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank),
    .blink(blink), .bright(bright), .seg(seg), .dp_out(dp_out), .an(an),
    .frame_tick(frame_tick)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(8), .DWELL_CYCLES(D), .BLINK_DIV(BD), .ACTIVE_LOW(1'b0)
  ) dut8 (
    .clk(clk), .rst(rst), .digits(digits8), .dp(dp8), .blank(blank8),
    .blink(blink8), .bright(bright8), .seg(seg8), .dp_out(dp_out8), .an(an8),
    .frame_tick(frame_tick8)
  );

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       ft;
  } exp_t;

  // Input history per cycle; index 0 = 4-digit DUT, 1 = 8-digit DUT.
  bit          rst_h   [HN];
  logic [31:0] dig_h   [2][HN];
  logic [7:0]  dp_h    [2][HN];
  logic [7:0]  blank_h [2][HN];
  logic [7:0]  blink_h [2][HN];
  logic [1:0]  br_h    [2][HN];

  logic [6:0] seg_tab [16];

  int cyc;
  int n_checks;
  int n_fail;

  // ---------------- driver ----------------
  task automatic step();
    if (cyc >= HN - 1) begin
      $display("FAIL history_overflow cyc=%0d limit=%0d", cyc, HN - 1);
      $fatal(1, "history overflow");
    end
    rst_h[cyc]      = rst;
    dig_h[0][cyc]   = {16'h0, digits};
    dp_h[0][cyc]    = {4'h0, dp};
    blank_h[0][cyc] = {4'h0, blank};
    blink_h[0][cyc] = {4'h0, blink};
    br_h[0][cyc]    = bright;
    dig_h[1][cyc]   = digits8;
    dp_h[1][cyc]    = dp8;
    blank_h[1][cyc] = blank8;
    blink_h[1][cyc] = blink8;
    br_h[1][cyc]    = bright8;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Cycles elapsed since the last reset cycle before c (c itself assumed
  // not in reset).
  function automatic int rel_t(input int c);
    int r;
    r = c - 1;
    while (r >= 0 && !rst_h[r]) r--;
    return c - (r + 1);
  endfunction

  // ---------------- reference model ----------------
  // Output visible during cycle c, derived from elapsed time since reset:
  // digit = (t/D) mod n, dwell position = t mod D, frame = t/(D*n),
  // blink phase off when (frame/BD) is odd. Digit attributes come from the
  // cycle that started the dwell; brightness from the cycle itself.
  function automatic exp_t model(input int c, input int w);
    exp_t        e;
    int          n, t, presc, idx, frame, on_time, t0;
    bit          al, off, lit;
    logic [31:0] dv;
    logic [3:0]  nib;
    logic [6:0]  seg_hi;
    n = (w == 1) ? 8 : 4;
    al = (w == 0);
    seg_hi = 7'h00;
    e.dp = 1'b0;
    e.an = 8'h00;
    e.ft = 1'b0;
    if (c >= 1 && !rst_h[c-1]) begin
      t = rel_t(c - 1);
      presc = t % D;
      idx = (t / D) % n;
      frame = t / (D * n);
      off = ((frame / BD) % 2) == 1;
      t0 = c - 1 - presc;
      dv = dig_h[w][t0];
      nib = dv[idx*4 +: 4];
      lit = !blank_h[w][t0][idx] && !(blink_h[w][t0][idx] && off);
      on_time = ((int'(br_h[w][c-1]) + 1) * D) / 4;
      if (lit) begin
        seg_hi = ~seg_tab[nib];
        e.dp = dp_h[w][t0][idx];
        if (presc < on_time) e.an = 8'(1 << idx);
      end
      e.ft = ((t + 1) % (D * n)) == 0;
    end
    if (al) begin
      e.seg = ~seg_hi;
      e.dp = ~e.dp;
      e.an = ~e.an;
    end else begin
      e.seg = seg_hi;
    end
    if (n == 4) e.an[7:4] = 4'h0;
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp_out, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset4 cyc=%0d got an=%b seg=%b dp=%b ft=%b exp an=1111 seg=1111111 dp=1 ft=0",
                 cyc, an, seg, dp_out, frame_tick);
      end
      n_checks++;
      if ({an8, seg8, dp_out8, frame_tick8} !== {8'h00, 7'h00, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset8 cyc=%0d got an=%b seg=%b dp=%b ft=%b exp all 0",
                 cyc, an8, seg8, dp_out8, frame_tick8);
      end
    end
    digits = 16'h3A71; dp = 4'h0; blank = 4'h0; blink = 4'h0; bright = 2'd3;
    rst = 1'b0;
    step();
    n_checks++;
    if ({an, seg} !== {4'b1110, 7'b1111001}) begin
      n_fail++;
      $display("FAIL release_digit0 got an=%b seg=%b exp an=1110 seg=1111001", an, seg);
    end
  endtask

  task automatic test_scan();
    exp_t e;
    int   ft_cnt;
    ft_cnt = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      e = model(cyc, 0);
      if (frame_tick === 1'b1) ft_cnt++;
      if ((cyc - 4) % D == 1) begin
        n_checks++;
        case ((cyc - 4) / D % 4)
          1: if ({an, seg} !== {4'b1101, 7'b1111000}) begin n_fail++; $display("FAIL scan_d1 got an=%b seg=%b exp 1101 1111000", an, seg); end
          2: if ({an, seg} !== {4'b1011, 7'b0001000}) begin n_fail++; $display("FAIL scan_d2 got an=%b seg=%b exp 1011 0001000", an, seg); end
          3: if ({an, seg} !== {4'b0111, 7'b0110000}) begin n_fail++; $display("FAIL scan_d3 got an=%b seg=%b exp 0111 0110000", an, seg); end
          default: if ({an, seg} !== {4'b1110, 7'b1111001}) begin n_fail++; $display("FAIL scan_d0 got an=%b seg=%b exp 1110 1111001", an, seg); end
        endcase
      end
      n_checks++;
      if ({seg, dp_out, an, frame_tick} !== {e.seg, e.dp, e.an[3:0], e.ft}) begin
        n_fail++;
        $display("FAIL scan cyc=%0d got seg=%b dp=%b an=%b ft=%b exp seg=%b dp=%b an=%b ft=%b",
                 cyc, seg, dp_out, an, frame_tick, e.seg, e.dp, e.an[3:0], e.ft);
      end
    end
    n_checks++;
    if (ft_cnt !== 2) begin
      n_fail++;
      $display("FAIL scan_frame_ticks got %0d exp 2", ft_cnt);
    end
  endtask

  task automatic test_bright_dp();
    exp_t e;
    dp = 4'b0010;
    for (int i = 0; i < 160; i++) begin
      if (i < 32) bright = 2'd1;
      else if (i < 64) bright = 2'd0;
      else if ($urandom_range(0, 3) == 0) bright = 2'($urandom_range(0, 3));
      if (i >= 96 && $urandom_range(0, 7) == 0) dp = 4'($urandom_range(0, 15));
      step();
      e = model(cyc, 0);
      n_checks++;
      if ({seg, dp_out, an, frame_tick} !== {e.seg, e.dp, e.an[3:0], e.ft}) begin
        n_fail++;
        $display("FAIL bright_dp cyc=%0d got seg=%b dp=%b an=%b ft=%b exp seg=%b dp=%b an=%b ft=%b",
                 cyc, seg, dp_out, an, frame_tick, e.seg, e.dp, e.an[3:0], e.ft);
      end
    end
  endtask

  task automatic test_blank_blink();
    exp_t e;
    int   an2_low;
    an2_low = 0;
    blank = 4'b0100; blink = 4'b0001; bright = 2'd3; dp = 4'b1111;
    for (int i = 0; i < 320; i++) begin
      if ($urandom_range(0, 2) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 9) == 0) bright = 2'($urandom_range(0, 3));
      step();
      e = model(cyc, 0);
      if (an[2] === 1'b0) an2_low++;
      n_checks++;
      if ({seg, dp_out, an, frame_tick} !== {e.seg, e.dp, e.an[3:0], e.ft}) begin
        n_fail++;
        $display("FAIL blank_blink cyc=%0d got seg=%b dp=%b an=%b ft=%b exp seg=%b dp=%b an=%b ft=%b",
                 cyc, seg, dp_out, an, frame_tick, e.seg, e.dp, e.an[3:0], e.ft);
      end
    end
    n_checks++;
    if (an2_low !== 0) begin
      n_fail++;
      $display("FAIL blanked_an2 got %0d lit cycles exp 0", an2_low);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   t;
    bit   found;
    found = 1'b0;
    bright = 2'd3; blank = 4'b0000; blink = 4'b0001;
    // Advance to mid-frame during the blink-off phase.
    for (int i = 0; i < 300 && !found; i++) begin
      t = rel_t(cyc);
      if (((t / (D * 4)) / BD) % 2 == 1 && (t % (D * 4)) == 13) begin
        found = 1'b1;
      end else begin
        step();
        e = model(cyc, 0);
        n_checks++;
        if ({seg, dp_out, an, frame_tick} !== {e.seg, e.dp, e.an[3:0], e.ft}) begin
          n_fail++;
          $display("FAIL pre_reset cyc=%0d got seg=%b an=%b exp seg=%b an=%b", cyc, seg, an, e.seg, e.an[3:0]);
        end
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_reset_setup got no blink-off mid-frame exp one within 300 cycles");
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({an, seg, dp_out, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_dark got an=%b seg=%b dp=%b ft=%b exp 1111 1111111 1 0", an, seg, dp_out, frame_tick);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (an !== 4'b1110) begin
      n_fail++;
      $display("FAIL mid_reset_restart got an=%b exp 1110", an);
    end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) digits = 16'($urandom);
      step();
      e = model(cyc, 0);
      n_checks++;
      if ({seg, dp_out, an, frame_tick} !== {e.seg, e.dp, e.an[3:0], e.ft}) begin
        n_fail++;
        $display("FAIL post_reset cyc=%0d got seg=%b dp=%b an=%b ft=%b exp seg=%b dp=%b an=%b ft=%b",
                 cyc, seg, dp_out, an, frame_tick, e.seg, e.dp, e.an[3:0], e.ft);
      end
    end
  endtask

  task automatic test_wide();
    exp_t e;
    int   ft_cnt;
    ft_cnt = 0;
    digits8 = 32'h76543210; bright8 = 2'd3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({an8, seg8} !== {8'b00000001, 7'b0111111}) begin
      n_fail++;
      $display("FAIL wide_first got an=%b seg=%b exp 00000001 0111111", an8, seg8);
    end
    for (int i = 0; i < 127; i++) begin
      if (i >= 64 && $urandom_range(0, 3) == 0) digits8 = $urandom;
      if (i >= 96 && $urandom_range(0, 5) == 0) bright8 = 2'($urandom_range(0, 3));
      step();
      e = model(cyc, 1);
      if (frame_tick8 === 1'b1) ft_cnt++;
      n_checks++;
      if ({seg8, dp_out8, an8, frame_tick8} !== {e.seg, e.dp, e.an, e.ft}) begin
        n_fail++;
        $display("FAIL wide cyc=%0d got seg=%b dp=%b an=%b ft=%b exp seg=%b dp=%b an=%b ft=%b",
                 cyc, seg8, dp_out8, an8, frame_tick8, e.seg, e.dp, e.an, e.ft);
      end
    end
    n_checks++;
    if (ft_cnt !== 2) begin
      n_fail++;
      $display("FAIL wide_frame_ticks got %0d exp 2", ft_cnt);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    cyc = 0; n_checks = 0; n_fail = 0;
    rst = 1'b1;
    digits = 16'h0; dp = 4'h0; blank = 4'h0; blink = 4'h0; bright = 2'd3;
    digits8 = 32'h0; dp8 = 8'h0; blank8 = 8'h0; blink8 = 8'h0; bright8 = 2'd3;

    test_reset();
    test_scan();
    test_bright_dp();
    test_blank_blink();
    test_mid_reset();
    test_wide();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
